// File: rtl/phrase_fetcher_if.sv
// Control, character-stream and SPI flash signals of phrase_fetcher.
// The master modport is the fetcher side. The slave modport is the planner/output/flash side.
interface phrase_fetcher_if;
  logic        start;
  logic [15:0] address;
  logic        busy;
  logic        done;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;

  modport master (
    input  start, address, char_ready, spi_miso,
    output busy, done, char_data, char_valid, spi_cs_n, spi_sclk, spi_mosi
  );

  modport slave (
    output start, address, char_ready, spi_miso,
    input  busy, done, char_data, char_valid, spi_cs_n, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/phrase_fetcher.sv
// Reads one phrase from SPI flash (READ 0x03, mode 0).
// Streams its bytes over valid/ready until a terminator is read or MAX_LEN bytes are sent.
module phrase_fetcher #(
  parameter int         CLK_DIV    = 2,
  parameter int         MAX_LEN    = 32,
  parameter logic [7:0] TERMINATOR = 8'h00
) (
  input logic             clk,
  input logic             nrst,
  phrase_fetcher_if.master bus
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]       LEN_LAST = 6'(MAX_LEN);
  localparam logic [7:0]       READ_CMD = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_EMIT   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [31:0]      shift_q, shift_d;
  logic [7:0]       rx_q, rx_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  // Next-state and next-output computation for the whole fetch sequence.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    valid_d   = valid_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d    = bus.address;
          shift_d   = {READ_CMD, 24'h00_0000};
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          sclk_d    = 1'b0;
          div_d     = '0;
          bit_cnt_d = 5'd0;
          cnt_d     = 6'd0;
          state_d   = S_CMD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CMD, S_ADDR: begin
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Falling edge: present the next MOSI bit while SCLK is low.
          if (sclk_q) begin
            shift_d   = {shift_q[30:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (state_q == S_CMD && bit_cnt_q == 5'd7) begin
              shift_d   = {8'h00, addr_q, 8'h00};
              bit_cnt_d = 5'd0;
              state_d   = S_ADDR;
            end else if (state_q == S_ADDR && bit_cnt_q == 5'd23) begin
              shift_d   = 32'h0000_0000;
              bit_cnt_d = 5'd0;
              state_d   = S_DATA;
            end else begin
              state_d = state_q;
            end
          end else begin
            shift_d = shift_q;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_DATA: begin
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_d = {rx_q[6:0], bus.spi_miso};
          end else if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            state_d   = S_EMIT;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_EMIT: begin
        if (!valid_q) begin
          if (rx_q == TERMINATOR) begin
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            valid_d = 1'b1;
            data_d  = rx_q;
          end
        end else if (bus.char_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 6'd1;
          // SCLK was parked low; the flash continues at the next address on resume.
          if (cnt_q + 6'd1 == LEN_LAST) begin
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            div_d   = '0;
            sclk_d  = 1'b0;
            state_d = S_DATA;
          end
        end else begin
          state_d = S_EMIT;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        shift_d = 32'h0000_0000;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer and raises CS at once.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      addr_q    <= 16'h0000;
      shift_q   <= 32'h0000_0000;
      rx_q      <= 8'h00;
      bit_cnt_q <= 5'd0;
      div_q     <= '0;
      cnt_q     <= 6'd0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      valid_q   <= 1'b0;
      data_q    <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.char_data  = data_q;
  assign bus.char_valid = valid_q;
  assign bus.spi_cs_n   = cs_n_q;
  assign bus.spi_sclk   = sclk_q;
  assign bus.spi_mosi   = shift_q[31];

endmodule

// File: tb/tb_phrase_fetcher.sv
// Bench for phrase_fetcher.
// A behavioural SPI flash plus an expected-byte queue built from flash contents, checked every cycle.
module tb_phrase_fetcher;
  localparam int MAX_LEN = 32;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  phrase_fetcher_if bif();

  phrase_fetcher #(.CLK_DIV(2), .MAX_LEN(MAX_LEN), .TERMINATOR(8'h00)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bif)
  );

  logic [7:0]  mem [0:65535];
  int          n_checks = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  int          exp_len = 0;
  int          n_acc = 0;
  int          done_cnt = 0;
  logic [7:0]  got [0:63];
  int          ready_mode = 3;
  int          stall_cnt = 0;

  int          rises = 0;
  logic [31:0] cmd_bits = 32'h0;
  int          last_rises = 0;
  logic [31:0] last_cmd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Flash: count SCLK rises, capture command/address bits.
  always @(posedge bif.spi_sclk) begin
    if (bif.spi_cs_n === 1'b0) begin
      if (rises < 32) cmd_bits = {cmd_bits[30:0], bif.spi_mosi};
      rises++;
    end
  end

  // Flash: shift out data MSB first on SCLK falling edges, auto-incrementing the address.
  always @(negedge bif.spi_sclk) begin
    if (bif.spi_cs_n === 1'b0 && rises >= 32) begin
      int k;
      logic [15:0] a;
      k = rises - 32;
      a = cmd_bits[15:0] + 16'(k / 8);
      bif.spi_miso = mem[a][7 - (k % 8)];
    end
  end

  always @(bif.spi_cs_n) begin
    if (bif.spi_cs_n === 1'b0) begin
      rises = 0;
      cmd_bits = 32'h0;
      bif.spi_miso = 1'b0;
    end else if (bif.spi_cs_n === 1'b1) begin
      last_rises = rises;
      last_cmd = cmd_bits;
    end
  end

  // Downstream ready pattern.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bif.char_ready = 1'b1;
      1: begin
        if (n_acc == 1 && bif.char_valid && stall_cnt < 50) begin
          bif.char_ready = 1'b0;
          stall_cnt++;
        end else begin
          bif.char_ready = 1'b1;
        end
      end
      default: bif.char_ready = 1'($urandom_range(0, 1));
    endcase
    if (ready_mode != 1) stall_cnt = 0;
  end

  // Per-cycle compare against the expected-byte queue and handshake rules.
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_done = 1'b0;
  always @(negedge clk) begin
    if (nrst !== 1'b1) begin
      prev_valid = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", 32'(bif.char_valid), 32'd1);
        chk("hold_data", 32'(bif.char_data), 32'(prev_data));
      end
      if (bif.char_valid) begin
        chk("sclk_low_while_valid", 32'(bif.spi_sclk), 32'd0);
        chk("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("char_data", 32'(bif.char_data), 32'(exp_q[0]));
        if (bif.char_ready) begin
          if (n_acc < 64) got[n_acc] = bif.char_data;
          n_acc++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      if (bif.done) begin
        done_cnt++;
        chk("done_busy_low", 32'(bif.busy), 32'd0);
        chk("done_cs_high", 32'(bif.spi_cs_n), 32'd1);
        chk("phrase_len", 32'(n_acc), 32'(exp_len));
        chk("done_single_cycle", 32'(prev_done), 32'd0);
      end
      prev_valid = bif.char_valid;
      prev_ready = bif.char_ready;
      prev_data  = bif.char_data;
      prev_done  = bif.done;
    end
  end

  task automatic build_expected(input logic [15:0] a);
    exp_q.delete();
    for (int i = 0; i < MAX_LEN; i++) begin
      logic [7:0] b;
      b = mem[16'(a + 16'(i))];
      if (b == 8'h00) break;
      exp_q.push_back(b);
    end
    exp_len = exp_q.size();
  endtask

  task automatic kick(input logic [15:0] a);
    build_expected(a);
    n_acc = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    bif.start = 1'b1;
    bif.address = a;
    @(posedge clk); #1;
    bif.start = 1'b0;
    bif.address = 16'($urandom);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_cnt == 0 && k < 5000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("done_timeout", 32'(done_cnt > 0), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("done_pulse_count", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    nrst = 1'b0;
    bif.start = 1'b0;
    bif.address = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0A60] = 8'h48; mem[16'h0A61] = 8'h49; mem[16'h0A62] = 8'h00;
    for (int i = 0; i <= 32; i++) mem[16'h0100 + i] = 8'h41 + 8'(i);
    mem[16'h0200] = 8'h61; mem[16'h0201] = 8'h62; mem[16'h0202] = 8'h63; mem[16'h0203] = 8'h00;
    mem[16'h0300] = 8'h4F; mem[16'h0301] = 8'h4B; mem[16'h0302] = 8'h00;
    mem[16'h0040] = 8'h58; mem[16'h0041] = 8'h59; mem[16'h0042] = 8'h00;
    mem[16'h0400] = 8'h51; mem[16'h0401] = 8'h00;
    mem[16'h0020] = 8'h5A; mem[16'h0021] = 8'h00;

    // Reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bif.start = 1'($urandom_range(0, 1));
      bif.address = 16'($urandom);
      @(negedge clk); #1;
      chk("rst_cs_n", 32'(bif.spi_cs_n), 32'd1);
      chk("rst_sclk", 32'(bif.spi_sclk), 32'd0);
      chk("rst_mosi", 32'(bif.spi_mosi), 32'd0);
      chk("rst_valid", 32'(bif.char_valid), 32'd0);
      chk("rst_data", 32'(bif.char_data), 32'd0);
      chk("rst_busy", 32'(bif.busy), 32'd0);
      chk("rst_done", 32'(bif.done), 32'd0);
    end
    @(posedge clk); #1;
    bif.start = 1'b0;
    nrst = 1'b1;
    ready_mode = 2;

    // "HI" phrase with random ready.
    kick(16'h0A60);
    chk("busy_after_start", 32'(bif.busy), 32'd1);
    wait_done();
    chk("hi_count", 32'(n_acc), 32'd2);
    chk("hi_byte0", 32'(got[0]), 32'h48);
    chk("hi_byte1", 32'(got[1]), 32'h49);
    chk("hi_cmd_addr", last_cmd, 32'h0300_0A60);
    chk("hi_data_rises", 32'(last_rises - 32), 32'd24);

    // 32 non-zero bytes: stop at MAX_LEN without a 33rd read.
    ready_mode = 0;
    kick(16'h0100);
    wait_done();
    chk("max_count", 32'(n_acc), 32'd32);
    chk("max_last_byte", 32'(got[31]), 32'h60);
    chk("max_total_rises", 32'(last_rises), 32'd288);

    // Stall on the second byte for 50 cycles.
    ready_mode = 1;
    kick(16'h0200);
    wait_done();
    chk("stall_cycles", 32'(stall_cnt), 32'd50);
    chk("stall_count", 32'(n_acc), 32'd3);
    chk("stall_byte1", 32'(got[1]), 32'h62);
    chk("stall_byte2", 32'(got[2]), 32'h63);
    chk("stall_data_rises", 32'(last_rises - 32), 32'd32);

    // Start while busy is ignored and not queued.
    ready_mode = 0;
    kick(16'h0300);
    repeat (100) @(posedge clk);
    #1;
    bif.start = 1'b1;
    bif.address = 16'h0040;
    @(posedge clk); #1;
    bif.start = 1'b0;
    chk("busy_mid", 32'(bif.busy), 32'd1);
    wait_done();
    chk("ign_count", 32'(n_acc), 32'd2);
    chk("ign_byte0", 32'(got[0]), 32'h4F);
    chk("ign_cmd_addr", last_cmd, 32'h0300_0300);
    repeat (30) @(negedge clk);
    #1;
    chk("ign_not_queued_busy", 32'(bif.busy), 32'd0);
    chk("ign_not_queued_cs", 32'(bif.spi_cs_n), 32'd1);

    // Reset during the address phase, then a clean transaction.
    kick(16'h0400);
    begin
      int k;
      k = 0;
      while (rises < 14 && k < 2000) begin
        @(negedge clk); #1;
        k++;
      end
      chk("reach_addr_phase", 32'(rises >= 14), 32'd1);
    end
    #2;
    nrst = 1'b0;
    #1;
    chk("abort_cs_n", 32'(bif.spi_cs_n), 32'd1);
    chk("abort_sclk", 32'(bif.spi_sclk), 32'd0);
    chk("abort_busy", 32'(bif.busy), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    kick(16'h0020);
    wait_done();
    chk("clean_count", 32'(n_acc), 32'd1);
    chk("clean_byte0", 32'(got[0]), 32'h5A);
    chk("clean_cmd_addr", last_cmd, 32'h0300_0020);
    chk("clean_data_rises", 32'(last_rises - 32), 32'd16);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
